// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter shared by instruction fetch and data access
//
// Purpose: sequences one access at a time through a fixed-latency memory on
// behalf of the IF-stage fetch port and the MEM-stage load/store port, and
// returns a one-cycle acknowledge to whichever side owned the access.
//
// Optional feature: define ARB_RR_EN for round-robin arbitration between the
// two requesters; left undefined, data always wins over fetch.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   if_req/if_addr      fetch request and address (held until if_ack)
//   if_rdata/if_ack     fetched word (valid in ack cycle, held) and ack pulse
//   d_req/d_we/d_addr   data request, store select, address (held until d_ack)
//   d_wdata             store data
//   d_rdata/d_ack       load data (valid in ack cycle, held) and ack pulse
//   mem_en/mem_we       one-cycle memory strobe and write enable
//   mem_addr/mem_wdata  memory address and write data (held until next grant)
//   mem_rdata           memory read data, valid MEM_LAT cycles after mem_en
//   stall_if/stall_mem  outstanding-request stalls for the hazard logic

module unified_mem_arbiter #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  // Counter runs MEM_LAT-1 .. 0 across WAIT so that cnt==0 lands on the
  // cycle in which the memory presents read data.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       own;       // 0 = fetch owns the access, 1 = data
  logic [3:0] cnt;
  logic       grant;
  logic       pick_d;

`ifdef ARB_RR_EN
  logic       last_d;    // side served most recently: 0 = fetch, 1 = data
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
`ifdef ARB_RR_EN
    // Contention goes to the side not served last; a lone request always wins.
    pick_d    = (d_req && if_req) ? ~last_d : d_req;
`else
    // Data belongs to the older instruction, so it always wins.
    pick_d    = d_req;
`endif
    case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          grant     = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = S_DONE;
        end
      end
      // Requests are deliberately not looked at here so a requester still
      // high in its ack cycle is not granted a second time.
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      own       <= 1'b0;
      cnt       <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      // mem_en is high only in ISSUE, i.e. the cycle after the grant.
      mem_en <= grant;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;

      if (grant) begin
        own      <= pick_d;
        mem_we   <= pick_d & d_we;
        mem_addr <= pick_d ? d_addr : if_addr;
        if (pick_d) begin
          mem_wdata <= d_wdata;
        end
      end

      if (state == S_ISSUE) begin
        cnt <= CNT_INIT;
      end

      // Ack is registered on the WAIT->DONE edge so it is high during DONE,
      // together with the freshly captured read data.
      if (state == S_WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (own) begin
          d_ack <= 1'b1;
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end

`ifdef ARB_RR_EN
      if (state == S_DONE) begin
        last_d <= own;
      end
`endif
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter

module tb_unified_mem_arbiter;

  localparam int AW  = 13;
  localparam int DW  = 32;
  localparam int LAT = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory seen by the DUT: word per address, read data appears exactly LAT
  // cycles after the strobe, random junk on every other cycle.
  logic [DW-1:0] phys    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] pipe    [0:LAT-1];

  always @(posedge CLK) begin
    pipe[0] <= $urandom;
    if (mem_en) begin
      if (mem_we) phys[mem_addr] <= mem_wdata;
      else        pipe[0] <= phys[mem_addr];
    end
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Scoreboard state
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] model_d_rdata = '0;
  int            gnt_side_q[$];
  int            gnt_cyc_q[$];
  int            grant_log[$];
  bit            last_srv_d = 1'b0;
  logic          p_if = 1'b0;
  logic          p_d  = 1'b0;

  // Monitor: fetch lives in addresses below 0x1000, data at 0x1000 and up.
  always @(negedge CLK) begin
    if (RST) begin
      gnt_side_q.delete();
      gnt_cyc_q.delete();
      last_srv_d = 1'b0;
    end else begin
      check("stall_if", stall_if, if_req & ~if_ack);
      check("stall_mem", stall_mem, d_req & ~d_ack);
      if (if_ack && d_ack) fail_now("both_acks");
      if (mem_en) begin
        int side;
        int win;
        side = int'(mem_addr[AW-1]);
        if (p_if || p_d) begin
          if (p_if && p_d) win = RR ? int'(!last_srv_d) : 1;
          else             win = int'(p_d);
          check("grant_side", side, win);
        end
        if (side == 1) begin
          check("mem_addr_d", mem_addr, d_addr);
          check("mem_we_d", mem_we, d_we);
          if (d_we) check("mem_wdata", mem_wdata, d_wdata);
        end else begin
          check("mem_addr_if", mem_addr, if_addr);
          check("mem_we_if", mem_we, 1'b0);
        end
        gnt_side_q.push_back(side);
        gnt_cyc_q.push_back(cyc);
        grant_log.push_back(side);
      end
      if (if_ack || d_ack) begin
        if (gnt_side_q.size() == 0) begin
          fail_now("ack_without_grant");
        end else begin
          int side;
          int c;
          side = gnt_side_q.pop_front();
          c    = gnt_cyc_q.pop_front();
          check("ack_side", int'(d_ack), side);
          check("ack_cycle", cyc, c + LAT + 1);
          last_srv_d = (side == 1);
        end
        if (if_ack) begin
          if (exp_if_q.size() == 0) fail_now("if_ack_unexpected");
          else check("if_rdata", if_rdata, exp_if_q.pop_front());
        end
        if (d_ack) begin
          if (exp_d_q.size() == 0) fail_now("d_ack_unexpected");
          else check("d_rdata", d_rdata, exp_d_q.pop_front());
        end
      end
    end
    p_if = if_req;
    p_d  = d_req;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    if_req = 1'b0;
    d_req  = 1'b0;
    step(2);
    RST = 1'b0;
    model_d_rdata = '0;
    exp_if_q.delete();
    exp_d_q.delete();
  endtask

  // Issue one fetch, wait (bounded) for its ack, measure cycles to ack.
  task automatic do_fetch(input logic [AW-1:0] a, input int exp_lat);
    int n;
    exp_if_q.push_back(ref_mem[a]);
    if_addr = a;
    if_req  = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!if_ack && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000)      fail_now("fetch_timeout");
    else if (exp_lat >= 0) check("fetch_latency", n, exp_lat);
    @(posedge CLK);
    #1;
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int exp_lat);
    int n;
    if (we) begin
      exp_d_q.push_back(model_d_rdata);
      ref_mem[a] = wd;
    end else begin
      model_d_rdata = ref_mem[a];
      exp_d_q.push_back(model_d_rdata);
    end
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!d_ack && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000)      fail_now("data_timeout");
    else if (exp_lat >= 0) check("data_latency", n, exp_lat);
    @(posedge CLK);
    #1;
    d_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacks;
    for (int i = 0; i < (1 << AW); i++) begin
      phys[i]    = $urandom;
      ref_mem[i] = phys[i];
    end
    phys[13'h010]    = 32'h8C08_0004;
    ref_mem[13'h010] = 32'h8C08_0004;

    // Reset state
    RST = 1'b1;
    step(3);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_if_rdata", if_rdata, '0);
    check("rst_d_rdata", d_rdata, '0);
    check("rst_acks", {if_ack, d_ack}, 2'b00);
    @(posedge CLK);
    #1;

    // Single fetch, then a store
    do_fetch(13'h010, LAT + 2);
    do_data(1'b1, 13'h1040, 32'hDEAD_BEEF, LAT + 2);

    // Simultaneous requests after reset: data first, fetch right behind
    apply_reset();
    fork
      do_data(1'b0, 13'h1040, '0, LAT + 2);
      do_fetch(13'h020, 2 * LAT + 5);
    join

    // Both sides held for several accesses: grant order
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) do_data(1'b0, AW'(13'h1000 + 4 * i), '0, -1);
      end
      begin
        for (int i = 0; i < (RR ? 2 : 1); i++) do_fetch(AW'(13'h030 + 4 * i), -1);
      end
    join
    if (grant_log.size() < 4) begin
      fail_now("grant_order_short");
    end else begin
      for (int i = 0; i < 4; i++)
        check($sformatf("grant_order_%0d", i), grant_log[i], RR ? ((i % 2 == 0) ? 1 : 0) : 1);
    end

    // Reset in the middle of a load
    step(1);
    model_d_rdata = ref_mem[13'h1080];
    d_we   = 1'b0;
    d_addr = 13'h1080;
    d_req  = 1'b1;
    step(2);
    RST = 1'b1;
    step(1);
    RST   = 1'b0;
    d_req = 1'b0;
    model_d_rdata = '0;
    exp_d_q.delete();
    @(negedge CLK);
    check("midrst_mem_en", mem_en, 1'b0);
    check("midrst_mem_we", mem_we, 1'b0);
    check("midrst_mem_addr", mem_addr, '0);
    check("midrst_mem_wdata", mem_wdata, '0);
    check("midrst_if_rdata", if_rdata, '0);
    check("midrst_d_rdata", d_rdata, '0);
    check("midrst_acks", {if_ack, d_ack}, 2'b00);
    nacks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (d_ack) nacks++;
    end
    check("midrst_no_ack", nacks, 0);
    @(posedge CLK);
    #1;

    // Back-to-back fetches after the reset
    for (int i = 0; i < 3; i++) do_fetch(AW'(13'h100 + 4 * i), LAT + 2);

    // Randomised traffic from both sides
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          step($urandom_range(0, 3));
          do_fetch(AW'($urandom_range(0, 'hFFF)), -1);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          step($urandom_range(0, 3));
          do_data(1'($urandom_range(0, 1)), AW'(13'h1000 + $urandom_range(0, 15)),
                  DW'($urandom), -1);
        end
      end
    join
    step(10);
    check("if_queue_drained", exp_if_q.size(), 0);
    check("d_queue_drained", exp_d_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Single-port memory arbiter for the 5-stage pipeline. Shares one physical memory port between the IF-stage instruction fetch and the MEM-stage load/store path. Sequences each access through a fixed-latency memory and returns per-requester acknowledges. Drives `stall_if`/`stall_mem`, which the hazard logic uses to freeze the PC, IF/ID and EX/MEM registers while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 13: byte address width, matching the PC width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: memory read latency in cycles. Legal range is 1–15.

Ports:
- `CLK` in 1: single clock. All state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `if_req` in 1: fetch request. Held high until `if_ack`.
- `if_addr` in ADDR_W: fetch address. Stable while `if_req` is high.
- `if_rdata` out DATA_W: fetched instruction. Valid in the `if_ack` cycle and held afterwards.
- `if_ack` out 1: one-cycle completion pulse for a fetch.
- `d_req` in 1: data request. Held high until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data. Valid in the `d_ack` cycle and held afterwards.
- `d_ack` out 1: one-cycle completion pulse for a data access.
- `mem_en` out 1: one-cycle access strobe to the memory.
- `mem_we` out 1: write enable. Qualified by `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data. Valid exactly MEM_LAT cycles after the `mem_en` cycle.
- `stall_if` out 1: `if_req & ~if_ack` (combinational).
- `stall_mem` out 1: `d_req & ~d_ack` (combinational).

## Operation
States:
- IDLE
- ISSUE
- WAIT
- DONE

Owner register `own`: 0 = fetch, 1 = data.

Transitions:
- IDLE:
  - If any request is pending, select a winner, latch its address, we and wdata into the `mem_*` registers, and go to ISSUE.
  - A fetch grant forces `mem_we = 0`.
- ISSUE:
  - `mem_en = 1` for this cycle only.
  - Load the 4-bit counter `cnt` with MEM_LAT−1 and go to WAIT.
- WAIT:
  - While `cnt != 0`, decrement.
  - When `cnt == 0`, this is the cycle in which `mem_rdata` is valid. Capture it into the owner's rdata register (loads and fetches only) and go to DONE.
- DONE:
  - Pulse the owner's ack.
  - All requests are ignored this cycle, so a requester that is still high in its ack cycle is not re-granted.
  - Go to IDLE.

Arbitration in IDLE:
- Data wins over fetch, because the data access belongs to the older instruction.
- Rotation is modified when the fairness macro is enabled (see Configuration).

Write (store) accesses:
- Follow the same state path and take the same latency as loads.
- `d_rdata` is left unchanged.

Other rules:
- `mem_addr`, `mem_we` and `mem_wdata` hold their values from ISSUE until the next grant.
- The address is passed through unmodified; no alignment check is done.
- Request inputs that drop before ack are a protocol violation. The access in flight still completes and the ack is still pulsed.

## Timing
- Request seen high in IDLE at cycle 0:
  - `mem_en` is high in cycle 1.
  - `mem_rdata` is sampled in cycle 1+MEM_LAT.
  - Ack is high in cycle 2+MEM_LAT.
  - IDLE is re-entered in cycle 3+MEM_LAT.
- Peak throughput is one access per MEM_LAT+3 cycles.
- Simultaneous `if_req` and `d_req` in IDLE: exactly one grant per IDLE cycle. The loser stays stalled and is re-evaluated in the next IDLE cycle.
- Reset values: state = IDLE, `own` = 0, `cnt` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `if_rdata` = 0, `d_rdata` = 0, `if_ack` = 0, `d_ack` = 0, last-served flag = 0 (fetch).
- Reset mid-access:
  - State returns to IDLE on the next edge and no ack is produced.
  - A `mem_en` already issued is not retracted.
- `stall_*` are combinational from the request inputs and the registered acks. Both are 0 in the ack cycle.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin arbitration. A 1-bit last-served flag is updated in DONE.
  - When both requests are pending in IDLE, the side not served last wins.
  - A single pending request always wins.
- `ARB_RR_EN` undefined:
  - Fixed data priority.
  - A continuously asserted `d_req` starves fetch.
  - The last-served flag is not implemented.

## Test plan
- Single fetch, MEM_LAT=2: `if_req` with `if_addr` = 0x010 at cycle 0, memory returns 0x8C080004 → `mem_en` = 1 with `mem_addr` = 0x010 and `mem_we` = 0 in cycle 1. `if_ack` = 1 with `if_rdata` = 0x8C080004 in cycle 4. `stall_if` = 1 in cycles 0–3.
- Store, MEM_LAT=2: `d_req` with `d_we` = 1, `d_addr` = 0x040, `d_wdata` = 0xDEADBEEF → cycle 1 shows `mem_en` = 1, `mem_we` = 1, `mem_wdata` = 0xDEADBEEF. `d_ack` in cycle 4. `d_rdata` unchanged.
- Simultaneous requests at cycle 0 → data is granted first (`d_ack` in cycle 4). Fetch `mem_en` is in cycle 6 and `if_ack` in cycle 9.
- Both requests held for 4 accesses:
  - With `ARB_RR_EN`, grant order is D, I, D, I.
  - Without it, order is D, D, D, D and `if_ack` is never seen.
- `RST` asserted in cycle 2 of a load → no `d_ack`, all outputs return to their reset values in cycle 3, and a new `if_req` is then served normally.
- MEM_LAT=1 → ack in cycle 3 after the request. Back-to-back fetches acknowledge every 4 cycles.
